sklansky_adder_pipe: RTL and testbench

Parametrised, pipelined Sklansky parallel-prefix adder with a valid/ready handshake on input and output. It computes y = a + b + cin with carry-out and spreads the log2(SIZE) prefix levels across a configurable number of register stages. Stalls propagate backward through the pipeline, and empty stages fill from upstream. It is the drop-in arithmetic core for datapath blocks that need a registered adder at widths and clock rates that one registered adder cannot meet.

---
 rtl/sklansky_adder_pipe_if.sv | 27 ++
 rtl/sklansky_adder_pipe.sv | 163 ++++++++++++++++
 tb/tb_sklansky_adder_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sklansky_adder_pipe_if.sv
// Operand/result bundle for sklansky_adder_pipe: valid/ready on both sides.
// master drives operands and the result ready.
// slave (the adder) drives in_ready and the registered result.
interface sklansky_adder_pipe_if #(
  parameter int SIZE = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] y;
  logic            cout;
  logic            ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, y, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, y, cout, ovf
  );
endinterface

// File: rtl/sklansky_adder_pipe.sv
// Pipelined Sklansky prefix adder y = a + b + cin, with cout and optional signed ovf (SKLANSKY_OVF_EN).
// Latency STAGES-1 cycles from the accepting edge to out_valid; one result per cycle.
// Each stage loads when it is empty or its downstream loads, so stalls ripple back and bubbles close.
module sklansky_adder_pipe #(
  parameter int SIZE   = 32,
  parameter int STAGES = 2
) (
  input logic                  clk,
  input logic                  rst,
  sklansky_adder_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(SIZE);

  // Partial prefix state carried between levels and across stage registers.
  typedef struct packed {
    logic [SIZE-1:0] g;
    logic [SIZE-1:0] p;
    logic [SIZE-1:0] p0;
    logic            cin;
`ifdef SKLANSKY_OVF_EN
    logic            a_msb;
`endif
  } node_t;

  // Prefix level after which stage register k sits.
  function automatic int stage_level(input int k);
    return (k * (LEVELS + 1)) / STAGES - 1;
  endfunction

  // Intermediate stage whose register follows level lvl, or 0 if none.
  function automatic int stage_at(input int lvl);
    int s;
    s = 0;
    for (int k = 1; k < STAGES; k++) begin
      if (stage_level(k) == lvl) s = k;
    end
    return s;
  endfunction

  logic [STAGES:1]   v;
  logic [STAGES+1:1] en;
  logic [STAGES:1]   up_valid;

  node_t n   [LEVELS+1];
  node_t stg [STAGES];

  logic [SIZE-1:0] sum;
  logic            sum_cout;
  logic [SIZE-1:0] y_q;
  logic            cout_q;

  // Load enables ripple from the output back to the input; upstream valids feed each stage.
  always_comb begin
    en = '0;
    up_valid = '0;
    en[STAGES+1] = bus.out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      en[k] = !v[k] | en[k+1];
    end
    up_valid[1] = bus.in_valid;
    for (int k = 2; k <= STAGES; k++) begin
      up_valid[k] = v[k-1];
    end
  end

  assign bus.in_ready  = en[1];
  assign bus.out_valid = v[STAGES];

  // Stage valid bits follow the upstream valid whenever the stage loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (en[k]) v[k] <= up_valid[k];
      end
    end
  end

  // Whole prefix tree; a level reads the stage register instead of the previous level where one sits between them.
  always_comb begin
    node_t cur;
    node_t nxt;
    int    span;
    int    src;
    cur  = '0;
    nxt  = '0;
    span = 0;
    src  = 0;
    for (int l = 0; l <= LEVELS; l++) n[l] = '0;

    n[0].p   = bus.a ^ bus.b;
    n[0].p0  = bus.a ^ bus.b;
    n[0].cin = bus.cin;
    // cin is folded into bit 0 so the tree only spans SIZE bits.
    n[0].g   = bus.a & bus.b;
    n[0].g[0] = (bus.a[0] & bus.b[0]) | ((bus.a[0] ^ bus.b[0]) & bus.cin);
`ifdef SKLANSKY_OVF_EN
    n[0].a_msb = bus.a[SIZE-1];
`endif

    for (int j = 1; j <= LEVELS; j++) begin
      if (stage_at(j - 1) != 0) cur = stg[stage_at(j - 1)];
      else                      cur = n[j-1];
      nxt  = cur;
      span = 1 << (j - 1);
      for (int i = 0; i < SIZE; i++) begin
        if ((i & span) != 0) begin
          // Top bit of the lower half of this 2*span block.
          src = (i & ~(2 * span - 1)) | (span - 1);
          nxt.g[i] = cur.g[i] | (cur.p[i] & cur.g[src]);
          nxt.p[i] = cur.p[i] & cur.p[src];
        end
      end
      n[j] = nxt;
    end
  end

  // Intermediate stage registers capture the tree state only for real transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        if (en[k] && up_valid[k]) stg[k] <= n[stage_level(k)];
      end
    end
  end

  assign sum      = n[LEVELS].p0 ^ {n[LEVELS].g[SIZE-2:0], n[LEVELS].cin};
  assign sum_cout = n[LEVELS].g[SIZE-1];

  // Final stage register holds the finished result.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      cout_q <= 1'b0;
    end else if (en[STAGES] && up_valid[STAGES]) begin
      y_q    <= sum;
      cout_q <= sum_cout;
    end
  end

  assign bus.y    = y_q;
  assign bus.cout = cout_q;

`ifdef SKLANSKY_OVF_EN
  logic ovf_q;

  // Signed overflow: operands agree in sign and the sum does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en[STAGES] && up_valid[STAGES]) begin
      ovf_q <= ~n[LEVELS].p0[SIZE-1] & (sum[SIZE-1] ^ n[LEVELS].a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_sklansky_adder_pipe.sv
// Directed bench for sklansky_adder_pipe across several SIZE/STAGES builds.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected ovf follows SKLANSKY_OVF_EN as seen by this file.
module tb_sklansky_adder_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;

`ifdef SKLANSKY_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  sklansky_adder_pipe_if #(.SIZE(32)) b32s3 ();
  sklansky_adder_pipe_if #(.SIZE(32)) b32s2 ();
  sklansky_adder_pipe_if #(.SIZE(32)) b32s4 ();
  sklansky_adder_pipe_if #(.SIZE(8))  b8 ();
  sklansky_adder_pipe_if #(.SIZE(2))  b2s1 ();
  sklansky_adder_pipe_if #(.SIZE(2))  b2s2 ();

  sklansky_adder_pipe #(.SIZE(32), .STAGES(3)) u32s3 (.clk(clk), .rst(rst), .bus(b32s3));
  sklansky_adder_pipe #(.SIZE(32), .STAGES(2)) u32s2 (.clk(clk), .rst(rst), .bus(b32s2));
  sklansky_adder_pipe #(.SIZE(32), .STAGES(4)) u32s4 (.clk(clk), .rst(rst), .bus(b32s4));
  sklansky_adder_pipe #(.SIZE(8),  .STAGES(2)) u8   (.clk(clk), .rst(rst), .bus(b8));
  sklansky_adder_pipe #(.SIZE(2),  .STAGES(1)) u2s1 (.clk(clk), .rst(rst), .bus(b2s1));
  sklansky_adder_pipe #(.SIZE(2),  .STAGES(2)) u2s2 (.clk(clk), .rst(rst), .bus(b2s2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ovf, cout, y} for a 32-bit add.
  function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] s;
    logic        o;
    s = {1'b0, a} + {1'b0, b} + {32'd0, c};
    o = OVF_ON & ~(a[31] ^ b[31]) & (s[31] ^ a[31]);
    return {o, s};
  endfunction

  // {ovf, cout, y} for a 2-bit add; v packs {a, b, cin}.
  function automatic logic [3:0] ref2(input int v);
    logic [1:0] aa;
    logic [1:0] bb;
    logic       cc;
    logic [2:0] s;
    logic       o;
    aa = v[4:3];
    bb = v[2:1];
    cc = v[0];
    s  = {1'b0, aa} + {1'b0, bb} + {2'd0, cc};
    o  = OVF_ON & ~(aa[1] ^ bb[1]) & (s[1] ^ aa[1]);
    return {o, s};
  endfunction

  task automatic idle_all();
    b32s3.in_valid = 0; b32s3.a = 0; b32s3.b = 0; b32s3.cin = 0; b32s3.out_ready = 1;
    b32s2.in_valid = 0; b32s2.a = 0; b32s2.b = 0; b32s2.cin = 0; b32s2.out_ready = 1;
    b32s4.in_valid = 0; b32s4.a = 0; b32s4.b = 0; b32s4.cin = 0; b32s4.out_ready = 1;
    b8.in_valid    = 0; b8.a    = 0; b8.b    = 0; b8.cin    = 0; b8.out_ready    = 1;
    b2s1.in_valid  = 0; b2s1.a  = 0; b2s1.b  = 0; b2s1.cin  = 0; b2s1.out_ready  = 1;
    b2s2.in_valid  = 0; b2s2.a  = 0; b2s2.b  = 0; b2s2.cin  = 0; b2s2.out_ready  = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_all();
    step();
    step();
    n_tot++;
    if ({b32s3.out_valid, b32s3.y, b32s3.cout, b32s3.ovf} !== 35'd0)
      $display("FAIL reset_s3: got v=%0b y=%h c=%0b o=%0b, want all 0", b32s3.out_valid, b32s3.y, b32s3.cout, b32s3.ovf);
    else n_pass++;
    n_tot++;
    if ({b32s4.out_valid, b32s4.y, b32s4.cout, b8.out_valid, b2s1.out_valid} !== 36'd0)
      $display("FAIL reset_others: got s4 v=%0b y=%h, s8 v=%0b, s2 v=%0b, want 0", b32s4.out_valid, b32s4.y, b8.out_valid, b2s1.out_valid);
    else n_pass++;
    rst = 0;
    #1;
    n_tot++;
    if (b32s3.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", b32s3.in_ready);
    else n_pass++;
  endtask

  task automatic test_single_op();
    b32s3.a = 32'hFFFF_FFFF; b32s3.b = 32'h0000_0001; b32s3.cin = 0; b32s3.in_valid = 1;
    step();
    b32s3.in_valid = 0;
    n_tot++;
    if (b32s3.out_valid !== 1'b0) $display("FAIL single_early0: out_valid got %0b want 0", b32s3.out_valid);
    else n_pass++;
    step();
    n_tot++;
    if (b32s3.out_valid !== 1'b0) $display("FAIL single_early1: out_valid got %0b want 0", b32s3.out_valid);
    else n_pass++;
    step();
    n_tot++;
    if ({b32s3.out_valid, b32s3.y, b32s3.cout, b32s3.ovf} !== {1'b1, 32'h0000_0000, 1'b1, 1'b0})
      $display("FAIL single_result: got v=%0b y=%h c=%0b o=%0b, want v=1 y=00000000 c=1 o=0", b32s3.out_valid, b32s3.y, b32s3.cout, b32s3.ovf);
    else n_pass++;
    // all-ones + all-ones + 1 wraps to all-ones with carry out
    b32s3.a = 32'hFFFF_FFFF; b32s3.b = 32'hFFFF_FFFF; b32s3.cin = 1; b32s3.in_valid = 1;
    step();
    b32s3.in_valid = 0;
    n_tot++;
    if (b32s3.out_valid !== 1'b0) $display("FAIL ones_retire: out_valid got %0b want 0", b32s3.out_valid);
    else n_pass++;
    step();
    step();
    n_tot++;
    if ({b32s3.out_valid, b32s3.y, b32s3.cout, b32s3.ovf} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0})
      $display("FAIL ones_result: got v=%0b y=%h c=%0b o=%0b, want v=1 y=ffffffff c=1 o=0", b32s3.out_valid, b32s3.y, b32s3.cout, b32s3.ovf);
    else n_pass++;
    step();
  endtask

  task automatic test_streaming();
    logic [33:0] ex [100];
    for (int i = 0; i < 102; i++) begin
      if (i >= 2) begin
        n_tot++;
        if ({b32s2.out_valid, b32s2.ovf, b32s2.cout, b32s2.y} !== {1'b1, ex[i-2]})
          $display("FAIL stream_%0d: got v=%0b o=%0b c=%0b y=%h, want v=1 {o,c,y}=%h", i - 2, b32s2.out_valid, b32s2.ovf, b32s2.cout, b32s2.y, ex[i-2]);
        else n_pass++;
      end
      if (i < 100) begin
        b32s2.a = $urandom;
        b32s2.b = (i % 10 == 0) ? ~b32s2.a : $urandom;
        b32s2.cin = 1'($urandom_range(1, 0));
        b32s2.in_valid = 1;
        ex[i] = ref32(b32s2.a, b32s2.b, b32s2.cin);
        #1;
        n_tot++;
        if (b32s2.in_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %0b want 1", i, b32s2.in_ready);
        else n_pass++;
      end else begin
        b32s2.in_valid = 0;
      end
      step();
    end
    n_tot++;
    if (b32s2.out_valid !== 1'b0) $display("FAIL stream_drained: out_valid got %0b want 0", b32s2.out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [33:0] ex [4];
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    int          acc;
    int          got;
    for (int k = 0; k < 4; k++) begin
      ta[k] = 32'h1000_0000 * (k + 1) + 32'h0000_00F0;
      tb[k] = 32'h0F00_0010 + 32'h0000_1111 * k;
      ex[k] = ref32(ta[k], tb[k], k[0]);
    end
    acc = 0;
    b32s3.out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      n_tot++;
      if (c < 3) begin
        if (b32s3.out_valid !== 1'b0) $display("FAIL bp_fill_%0d: out_valid got %0b want 0", c, b32s3.out_valid);
        else n_pass++;
      end else begin
        if ({b32s3.out_valid, b32s3.ovf, b32s3.cout, b32s3.y} !== {1'b1, ex[0]})
          $display("FAIL bp_hold_%0d: got v=%0b o=%0b c=%0b y=%h, want v=1 {o,c,y}=%h", c, b32s3.out_valid, b32s3.ovf, b32s3.cout, b32s3.y, ex[0]);
        else n_pass++;
      end
      b32s3.a = ta[acc < 3 ? acc : 3]; b32s3.b = tb[acc < 3 ? acc : 3]; b32s3.cin = (acc % 2) == 1;
      b32s3.in_valid = 1;
      #1;
      n_tot++;
      if (b32s3.in_ready !== (c < 3)) $display("FAIL bp_ready_%0d: got %0b want %0b", c, b32s3.in_ready, c < 3);
      else n_pass++;
      if (c < 3) acc++;
      step();
    end
    // Full pipe: retire and accept at the same edge.
    b32s3.out_ready = 1;
    b32s3.a = ta[3]; b32s3.b = tb[3]; b32s3.cin = 1;
    #1;
    n_tot++;
    if (b32s3.in_ready !== 1'b1) $display("FAIL bp_full_accept: in_ready got %0b want 1", b32s3.in_ready);
    else n_pass++;
    step();
    b32s3.in_valid = 0;
    got = 1;
    for (int c = 0; c < 12; c++) begin
      if (b32s3.out_valid === 1'b1) begin
        n_tot++;
        if (got >= 4) $display("FAIL bp_extra: unexpected result y=%h", b32s3.y);
        else if ({b32s3.ovf, b32s3.cout, b32s3.y} !== ex[got])
          $display("FAIL bp_drain_%0d: got {o,c,y}=%h want %h", got, {b32s3.ovf, b32s3.cout, b32s3.y}, ex[got]);
        else n_pass++;
        got++;
      end
      step();
    end
    n_tot++;
    if (got !== 4) $display("FAIL bp_count: got %0d results want 4", got);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    b32s4.a = 32'd5; b32s4.b = 32'd7; b32s4.cin = 1; b32s4.in_valid = 1;
    step();
    b32s4.in_valid = 0;
    step(); step(); step();
    n_tot++;
    if ({b32s4.out_valid, b32s4.y, b32s4.cout} !== {1'b1, 32'd13, 1'b0})
      $display("FAIL mf_warmup: got v=%0b y=%h c=%0b want v=1 y=0000000d c=0", b32s4.out_valid, b32s4.y, b32s4.cout);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      b32s4.a = 32'hA000_0000 + k; b32s4.b = 32'h7000_0000; b32s4.cin = 0; b32s4.in_valid = 1;
      #1;
      n_tot++;
      if (b32s4.in_ready !== 1'b1) $display("FAIL mf_accept_%0d: in_ready got %0b want 1", k, b32s4.in_ready);
      else n_pass++;
      step();
    end
    b32s4.in_valid = 0;
    rst = 1;
    step();
    rst = 0;
    n_tot++;
    if ({b32s4.out_valid, b32s4.y, b32s4.cout} !== 34'd0)
      $display("FAIL mf_after_rst: got v=%0b y=%h c=%0b want all 0", b32s4.out_valid, b32s4.y, b32s4.cout);
    else n_pass++;
    #1;
    n_tot++;
    if (b32s4.in_ready !== 1'b1) $display("FAIL mf_ready: in_ready got %0b want 1", b32s4.in_ready);
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      step();
      n_tot++;
      if (b32s4.out_valid !== 1'b0) $display("FAIL mf_stale_%0d: out_valid got %0b y=%h want 0", c, b32s4.out_valid, b32s4.y);
      else n_pass++;
    end
    b32s4.a = 32'h1234_5678; b32s4.b = 32'h1111_1111; b32s4.cin = 1; b32s4.in_valid = 1;
    step();
    b32s4.in_valid = 0;
    step(); step(); step();
    n_tot++;
    if ({b32s4.out_valid, b32s4.y, b32s4.cout} !== {1'b1, 32'h2345_678A, 1'b0})
      $display("FAIL mf_resume: got v=%0b y=%h c=%0b want v=1 y=2345678a c=0", b32s4.out_valid, b32s4.y, b32s4.cout);
    else n_pass++;
  endtask

  task automatic test_overflow();
    // {a, b, cin, y, cout, ovf-if-enabled}
    logic [26:0] tbl [6];
    tbl[0] = {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[1] = {8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[2] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3] = {8'h40, 8'h3F, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[4] = {8'hC0, 8'hC0, 1'b1, 8'h81, 1'b1, 1'b0};
    tbl[5] = {8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      b8.a = tbl[k][26:19]; b8.b = tbl[k][18:11]; b8.cin = tbl[k][10]; b8.in_valid = 1;
      step();
      b8.in_valid = 0;
      step();
      n_tot++;
      if ({b8.out_valid, b8.y, b8.cout, b8.ovf} !== {1'b1, tbl[k][9:1], tbl[k][0] & OVF_ON})
        $display("FAIL ovf_%0d: got v=%0b y=%h c=%0b o=%0b want v=1 y=%h c=%0b o=%0b", k, b8.out_valid, b8.y, b8.cout, b8.ovf, tbl[k][9:2], tbl[k][1], tbl[k][0] & OVF_ON);
      else n_pass++;
    end
  endtask

  task automatic test_corner_widths();
    logic [3:0] e;
    for (int i = 0; i < 34; i++) begin
      if (i >= 1 && i <= 32) begin
        e = ref2(i - 1);
        n_tot++;
        if ({b2s1.out_valid, b2s1.ovf, b2s1.cout, b2s1.y} !== {1'b1, e})
          $display("FAIL w2s1_%0d: got v=%0b o=%0b c=%0b y=%0d want v=1 {o,c,y}=%h", i - 1, b2s1.out_valid, b2s1.ovf, b2s1.cout, b2s1.y, e);
        else n_pass++;
      end
      if (i >= 2) begin
        e = ref2(i - 2);
        n_tot++;
        if ({b2s2.out_valid, b2s2.ovf, b2s2.cout, b2s2.y} !== {1'b1, e})
          $display("FAIL w2s2_%0d: got v=%0b o=%0b c=%0b y=%0d want v=1 {o,c,y}=%h", i - 2, b2s2.out_valid, b2s2.ovf, b2s2.cout, b2s2.y, e);
        else n_pass++;
      end
      if (i < 32) begin
        b2s1.a = 2'(i >> 3); b2s1.b = 2'(i >> 1); b2s1.cin = 1'(i);
        b2s2.a = 2'(i >> 3); b2s2.b = 2'(i >> 1); b2s2.cin = 1'(i);
        b2s1.in_valid = 1;
        b2s2.in_valid = 1;
      end else begin
        b2s1.in_valid = 0;
        b2s2.in_valid = 0;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_all();
    test_reset();
    test_single_op();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_overflow();
    test_corner_widths();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
